// File: rtl/aes_result_drain.sv
// Drain stage for the AES-128 core: captures the ciphertext block when pc reaches
// DONE_PC, queues it in a small FIFO and streams it out as W-bit beats.
module aes_result_drain #(
  parameter int          VLEN    = 128,
  parameter int          W       = 32,
  parameter int          DEPTH   = 4,
  parameter logic [31:0] DONE_PC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     pc,
  input  logic [VLEN-1:0] mem,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            overflow,
  output logic [15:0]     blk_count
);

  localparam int BEATS  = VLEN / W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic                match, match_q, cap;
  logic                pop, push_ok, hs, is_last, empty, full;
  logic [VLEN-1:0]     fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [BEAT_W-1:0]   beat_q;
  logic [VLEN-1:0]     sh;
  logic                overflow_q;
  logic [15:0]         blk_count_q;

  // Capture: rising edge of the pc==DONE_PC condition
  assign match   = (pc == DONE_PC);
  assign cap     = match & ~match_q;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign is_last = (beat_q == BEAT_W'(BEATS - 1));
  assign hs      = (state_q == SEND) && out_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle
  assign push_ok = cap && (!full || pop);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && is_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: pointers, occupancy, beat index, status
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      match_q     <= 1'b1;
      beat_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match;
      if (pop) begin
        beat_q <= '0;
        rd_ptr <= rd_ptr + PTR_W'(1);
      end else if (hs) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
      if (push_ok) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        blk_count_q <= blk_count_q + 16'd1;
      end
      if (cap && !push_ok) overflow_q <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data path: FIFO storage and output shift register carry no reset
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= mem;
    if (pop) begin
      sh <= fifo_mem[rd_ptr];
    end else if (hs) begin
      sh <= sh >> W;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? sh[W-1:0] : '0;
  assign out_last  = out_valid && is_last;
  assign busy      = !empty || (state_q != IDLE);
  assign overflow  = overflow_q;
  assign blk_count = blk_count_q;

endmodule

// File: tb/tb_aes_result_drain.sv
// Directed bench for aes_result_drain: capture, streaming, backpressure,
// overflow, full-with-pop and mid-block reset.
module tb_aes_result_drain;

  localparam logic [31:0] DONE = 32'h0000_0100;
  localparam logic [31:0] AWAY = 32'h0000_00FC;

  logic         clk = 1'b0;
  logic         clr;
  logic [31:0]  pc;
  logic [127:0] mem;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         overflow;
  logic [15:0]  blk_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] bq[$];
  logic        lq[$];

  always #5 clk = ~clk;

  aes_result_drain #(
    .VLEN(128), .W(32), .DEPTH(4), .DONE_PC(DONE)
  ) dut (
    .clk(clk), .clr(clr), .pc(pc), .mem(mem),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overflow(overflow), .blk_count(blk_count)
  );

  // Record every beat that will be accepted at the coming rising edge
  always @(negedge clk) begin
    if (out_valid && out_ready && !clr) begin
      bq.push_back(out_data);
      lq.push_back(out_last);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] blk(input int k);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'hA500_0000 + 32'(k) * 32'd256 + 32'(j);
    return r;
  endfunction

  // One entry into DONE_PC: leaves the bench one cycle after the capture cycle
  task automatic do_cap(input logic [127:0] m);
    pc = AWAY;
    tick();
    pc  = DONE;
    mem = m;
    tick();
    pc = AWAY;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 128'(busy), 128'(0));
  endtask

  task automatic chk_stream(input string tag, input int k0, input int nblk);
    logic [127:0] b;
    chk({tag, "_n"}, 128'(bq.size()), 128'(nblk * 4));
    for (int i = 0; i < nblk * 4; i++) begin
      if (i < bq.size()) begin
        b = blk(k0 + i / 4);
        chk($sformatf("%s_d%0d", tag, i), 128'(bq[i]), 128'(b[(i % 4) * 32 +: 32]));
        chk($sformatf("%s_l%0d", tag, i), 128'(lq[i]), 128'((i % 4) == 3));
      end
    end
  endtask

  initial begin
    logic [127:0] m2;
    logic [31:0]  exp2 [4];
    logic [127:0] b;

    // 1: reset held with pc at DONE_PC
    clr = 1'b1; pc = DONE; mem = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data",  128'(out_data),  128'(0));
    chk("rst_last",  128'(out_last),  128'(0));
    chk("rst_busy",  128'(busy),      128'(0));
    chk("rst_ovf",   128'(overflow),  128'(0));
    chk("rst_cnt",   128'(blk_count), 128'(0));
    clr = 1'b0;
    tick(); tick(); tick();
    chk("rel_cnt",  128'(blk_count), 128'(0));
    chk("rel_busy", 128'(busy),      128'(0));

    // 2: single block, pc held at DONE_PC afterwards
    m2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    exp2 = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    bq.delete(); lq.delete();
    pc = AWAY;
    tick();
    pc = DONE; mem = m2; out_ready = 1'b1;
    tick();
    chk("t2_lat1_valid", 128'(out_valid), 128'(0));
    chk("t2_lat1_busy",  128'(busy),      128'(1));
    chk("t2_cnt",        128'(blk_count), 128'(1));
    tick();
    chk("t2_lat2_valid", 128'(out_valid), 128'(1));
    chk("t2_lat2_data",  128'(out_data),  128'(32'hCCDDEEFF));
    wait_idle("t2_idle");
    chk("t2_n", 128'(bq.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < bq.size()) begin
        chk($sformatf("t2_d%0d", i), 128'(bq[i]), 128'(exp2[i]));
        chk($sformatf("t2_l%0d", i), 128'(lq[i]), 128'(i == 3));
      end
    end
    chk("t2_norecap", 128'(blk_count), 128'(1));
    pc = AWAY;

    // 3: backpressure mid-block
    bq.delete(); lq.delete();
    out_ready = 1'b0;
    b = blk(3);
    do_cap(b);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 128'(out_valid), 128'(1));
      chk("t3_hold_data",  128'(out_data),  128'(b[63:32]));
      chk("t3_hold_last",  128'(out_last),  128'(0));
    end
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_lhold_valid", 128'(out_valid), 128'(1));
      chk("t3_lhold_data",  128'(out_data),  128'(b[127:96]));
      chk("t3_lhold_last",  128'(out_last),  128'(1));
    end
    out_ready = 1'b1;
    wait_idle("t3_idle");
    chk_stream("t3", 3, 1);
    chk("t3_cnt", 128'(blk_count), 128'(2));

    // 4: overflow; serialiser holds one block and the FIFO four more
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) do_cap(blk(k));
    chk("t4_ovf_pre", 128'(overflow),  128'(0));
    chk("t4_cnt_pre", 128'(blk_count), 128'(5));
    do_cap(blk(6));
    chk("t4_ovf",     128'(overflow),  128'(1));
    chk("t4_cnt",     128'(blk_count), 128'(5));
    bq.delete(); lq.delete();
    out_ready = 1'b1;
    wait_idle("t4_idle");
    chk_stream("t4", 1, 5);
    chk("t4_ovf_sticky", 128'(overflow), 128'(1));

    // 5: capture lands on the pop cycle while the FIFO is full
    do_reset();
    out_ready = 1'b0;
    for (int k = 11; k <= 15; k++) do_cap(blk(k));
    chk("t5_cnt_pre", 128'(blk_count), 128'(5));
    bq.delete(); lq.delete();
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t5_bubble", 128'(out_valid), 128'(0));
    pc = DONE; mem = blk(16);
    tick();
    pc = AWAY;
    chk("t5_cnt", 128'(blk_count), 128'(6));
    chk("t5_ovf", 128'(overflow),  128'(0));
    wait_idle("t5_idle");
    chk_stream("t5", 11, 6);

    // 6: reset during beat 2 discards the rest of the block
    do_reset();
    bq.delete(); lq.delete();
    out_ready = 1'b1;
    b = blk(21);
    do_cap(b);
    tick(); tick(); tick();
    chk("t6_beat2", 128'(out_data), 128'(b[95:64]));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_valid", 128'(out_valid), 128'(0));
    chk("t6_busy",  128'(busy),      128'(0));
    chk("t6_cnt",   128'(blk_count), 128'(0));
    tick(); tick(); tick();
    chk("t6_n", 128'(bq.size()), 128'(2));
    bq.delete(); lq.delete();
    do_cap(blk(22));
    wait_idle("t6_idle");
    chk_stream("t6b", 22, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
